// File: rtl/hex_keypad_entry.sv
// Scans a 4x4 active-low hex keypad, debounces press and release, and shifts
// each accepted key code into a DATA_W-bit operand register.
module hex_keypad_entry #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int DATA_W         = 16
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [3:0]        row_in,
    output logic [3:0]        col_out,
    input  logic              clear,
    output logic [DATA_W-1:0] entry_data,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output logic [2:0]        digit_cnt
);

    localparam int DIV_W  = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
    localparam int DIGITS = DATA_W / 4;
    localparam logic [2:0] DIGIT_MAX = (DIGITS > 7) ? 3'd7 : 3'(DIGITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [3:0]        col_out_q, col_out_d;
    logic [3:0]        cand_q, cand_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] entry_q, entry_d;
    logic [3:0]        key_code_q, key_code_d;
    logic              key_valid_q, key_valid_d;
    logic [2:0]        digit_q, digit_d;

    logic              tick;
    logic              key_hit;
    logic [1:0]        row_idx;
    logic [3:0]        code;
    logic              accept;
    logic [DATA_W+3:0] entry_shift;

    assign tick = (div_q == DIV_LAST);

    // A key is only recognised when exactly one row is pulled low.
    always_comb begin
        key_hit = 1'b1;
        row_idx = 2'd0;
        case (row_in)
            4'b1110: row_idx = 2'd0;
            4'b1101: row_idx = 2'd1;
            4'b1011: row_idx = 2'd2;
            4'b0111: row_idx = 2'd3;
            default: key_hit = 1'b0;
        endcase
        code = {row_idx, col_idx_q};
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        div_d     = tick ? '0 : div_q + DIV_W'(1);

        case (state_q)
            SCAN: begin
                if (tick) begin
                    if (key_hit) begin
                        cand_d = code;
                        if (DEBOUNCE_SCANS <= 1) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
            end
            DEBOUNCE: begin
                if (tick) begin
                    if (key_hit && (code == cand_q)) begin
                        if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            accept  = 1'b1;
                            cnt_d   = '0;
                            state_d = HOLD;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d     = '0;
                        col_idx_d = col_idx_q + 2'd1;
                        state_d   = SCAN;
                    end
                end
            end
            HOLD: begin
                // Release count restarts whenever any row is still low.
                if (tick) begin
                    if (row_in == 4'b1111) begin
                        if (cnt_q + CNT_W'(1) == CNT_DONE) begin
                            cnt_d     = '0;
                            col_idx_d = col_idx_q + 2'd1;
                            state_d   = SCAN;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = SCAN;
            end
        endcase

        col_out_d = ~(4'b0001 << col_idx_d);
    end

    always_comb begin
        key_valid_d = accept;
        key_code_d  = accept ? code : key_code_q;
        entry_shift = {entry_q, code};
        entry_d     = entry_q;
        digit_d     = digit_q;
        // Clear has priority over a key accepted on the same edge.
        if (clear) begin
            entry_d = '0;
            digit_d = 3'd0;
        end else if (accept) begin
            entry_d = entry_shift[DATA_W-1:0];
            if (digit_q != DIGIT_MAX) begin
                digit_d = digit_q + 3'd1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q     <= SCAN;
            div_q       <= '0;
            col_idx_q   <= 2'd0;
            col_out_q   <= 4'b1110;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            entry_q     <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            digit_q     <= 3'd0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            col_idx_q   <= col_idx_d;
            col_out_q   <= col_out_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            entry_q     <= entry_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            digit_q     <= digit_d;
        end
    end

    assign col_out    = col_out_q;
    assign entry_data = entry_q;
    assign key_code   = key_code_q;
    assign key_valid  = key_valid_q;
    assign digit_cnt  = digit_q;

endmodule

// File: doc/hex_keypad_entry.md
Name: hex_keypad_entry

Overview:
Input-side counterpart of the 7-segment display driver. Scans a 4x4 active-low hex keypad and debounces presses. Each accepted key is shifted into a 16-bit operand register, which is the s_data source the display and CPU datapath read. Sits between the board keypad pins and the operand/display path.

Parameters:
SCAN_DIV, 1000, clock cycles each column stays driven; one "sample tick" per column slot (min 2)
DEBOUNCE_SCANS, 8, consecutive matching sample ticks needed to accept a press or a release (min 1)
DATA_W, 16, operand width; must be a multiple of 4

Ports:
CLK  input  1  system clock; all logic on rising edge
RST_n  input  1  synchronous active-low reset
row_in  input  4  keypad rows, active-low, externally pulled up, already synchronised
col_out  output  4  keypad column drive, active-low, exactly one bit low while scanning
clear  input  1  synchronous operand clear, level, active-high
entry_data  output  DATA_W  assembled operand, newest digit in bits [3:0]
key_code  output  4  code of the last accepted key
key_valid  output  1  one-cycle pulse when a key is accepted
digit_cnt  output  3  digits entered since reset/clear, saturates at DATA_W/4

Behaviour:
- Reset (RST_n=0 at an edge): col_out=4'b1110 (column 0), entry_data=0, key_code=0, key_valid=0, digit_cnt=0, state=SCAN, divider=0, debounce counter=0. Reset mid-debounce or mid-hold aborts with no key_valid pulse.
- Divider counts 0..SCAN_DIV-1. The sample tick is the cycle where divider==SCAN_DIV-1. Rows are sampled only on ticks, so the column line has settled for SCAN_DIV-1 cycles.
- Key decode: valid only when exactly one row bit is 0. code = {row_idx[1:0], col_idx[1:0]}, e.g. row 2, col 1 -> 4'h9. Zero or two or more low rows count as "no key".
- SCAN: on each tick with no key, advance column 0->1->2->3->0 (col_out 1110->1101->1011->0111->1110). On a tick with a valid key, latch candidate code, hold the current column, set the debounce count to 1 and go to DEBOUNCE.
- DEBOUNCE: column frozen. On each tick:
  - Same valid code: increment count.
  - Anything else: go back to SCAN, column keeps advancing from the held column.
  - When count reaches DEBOUNCE_SCANS: accept the key and go to HOLD. With DEBOUNCE_SCANS=1 the key is accepted on the first detecting tick.
- Accept, registered, visible on the cycle after the accepting tick:
  - key_valid=1 for exactly one cycle.
  - key_code=code.
  - entry_data <= {entry_data[DATA_W-5:0], code}; the oldest digit falls off.
  - digit_cnt increments, saturating at DATA_W/4.
- HOLD: column frozen; waits for release. Each tick with all rows high increments the release count; any tick with a row low resets it to 0. At DEBOUNCE_SCANS, advance to the next column and return to SCAN. Holding a key never repeats, and a second key pressed during HOLD is ignored.
- clear=1: entry_data=0 and digit_cnt=0 on the next edge. Scanning and FSM are unaffected.
  - clear wins over a simultaneous accept: key_valid and key_code still update, but entry_data stays 0 and digit_cnt stays 0.
- Column-drive glitches are forbidden: col_out comes straight from a register.

Test Plan:
- Reset with SCAN_DIV=4, DEBOUNCE_SCANS=3 -> col_out=1110, entry_data=0, digit_cnt=0; column advances every 4 cycles, wrapping 0111->1110.
- Press row1/col2 stable (row_in=1101 while col 2 low) -> exactly one key_valid pulse with key_code=4'h6, on the cycle after the 3rd matching tick; entry_data=16'h0006, digit_cnt=1; holding 50 ticks gives no further pulse.
- Bouncy press: key low for 1 tick, high for 1 tick, then stable -> no pulse during bounce; a single accept after 3 stable ticks.
- Enter keys 1,2,3,4,5 with releases between -> entry_data goes 0001, 0012, 0123, 1234, 2345; digit_cnt saturates at 4.
- Two rows low simultaneously -> no accept, scan keeps advancing; clear asserted on the accept cycle -> entry_data=0, key_valid still pulses.
- RST_n=0 during DEBOUNCE and during HOLD -> no key_valid pulse; all outputs return to reset values; normal entry works afterwards.
